// File: rtl/adc_sequencer.sv
// adc_sequencer: round-robin ADC channel scanner with a result register file and a read port
module adc_sequencer #(
  parameter int NUM_CH  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clock_clk,
  input  logic              reset_sink_reset_n,
  input  logic              enable,
  input  logic [NUM_CH-1:0] chan_mask,
  input  logic              clear_err,
  output logic              command_valid,
  output logic [4:0]        command_channel,
  output logic              command_startofpacket,
  output logic              command_endofpacket,
  input  logic              command_ready,
  input  logic              response_valid,
  input  logic [4:0]        response_channel,
  input  logic [11:0]       response_data,
  input  logic [2:0]        rd_addr,
  output logic [11:0]       rd_data,
  output logic [NUM_CH-1:0] result_valid,
  output logic              busy,
  output logic              scan_done,
  output logic              timeout_err,
  output logic              chan_err
);
  localparam int SW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, CMD, WAIT, NEXT} state_e;
  state_e            state_q, state_d;
  logic [SW-1:0]     slot_q, slot_d;
  logic [NUM_CH-1:0] scan_mask_q, scan_mask_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              done_q, done_d;
  logic              terr_q, terr_d;
  logic              cerr_q, cerr_d;
  logic [11:0]       res_q [NUM_CH];
  logic [NUM_CH-1:0] vld_q;
  logic [11:0]       rd_q;
  logic [4:0]        slot_ch;
  logic              hit, wr;
  logic [SW:0]       pick_lo, pick_nx;

  // Lowest set bit of m at or above lo; MSB of the result flags "found".
  function automatic logic [SW:0] pick(input logic [NUM_CH-1:0] m, input int lo);
    pick = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i] && i >= lo) pick = {1'b1, SW'(i)};
  endfunction

  assign slot_ch               = 5'(slot_q) + 5'd1;
  assign hit                   = response_valid && response_channel == slot_ch;
  assign pick_lo               = pick(chan_mask, 0);
  assign pick_nx               = pick(scan_mask_q, int'(slot_q) + 1);
  assign command_valid         = state_q == CMD;
  assign command_channel       = command_valid ? slot_ch : 5'd0;
  assign command_startofpacket = command_valid;
  assign command_endofpacket   = command_valid;
  assign busy                  = state_q != IDLE;
  assign scan_done             = done_q;
  assign timeout_err           = terr_q;
  assign chan_err              = cerr_q;
  assign rd_data               = rd_q;
  assign result_valid          = vld_q;

  // Next-state logic: slot walk, response matching, timeout and sticky errors.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    scan_mask_d = scan_mask_q;
    tmo_d       = tmo_q;
    done_d      = 1'b0;
    wr          = 1'b0;
    terr_d      = terr_q & ~clear_err;
    cerr_d      = (cerr_q & ~clear_err) | (response_valid && (state_q != WAIT || !hit));
    case (state_q)
      IDLE: if (enable && pick_lo[SW]) begin
        scan_mask_d = chan_mask;
        slot_d      = pick_lo[SW-1:0];
        state_d     = CMD;
      end
      CMD: if (command_ready) begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: if (hit) begin
        wr      = 1'b1;
        state_d = NEXT;
      end else if (tmo_q == TW'(TIMEOUT - 1)) begin
        terr_d  = 1'b1;
        state_d = NEXT;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
      NEXT: if (enable && pick_nx[SW]) begin
        slot_d  = pick_nx[SW-1:0];
        state_d = CMD;
      end else begin
        done_d  = enable;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
    if (!reset_sink_reset_n) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      scan_mask_q <= '0;
      tmo_q       <= '0;
      done_q      <= 1'b0;
      terr_q      <= 1'b0;
      cerr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      scan_mask_q <= scan_mask_d;
      tmo_q       <= tmo_d;
      done_q      <= done_d;
      terr_q      <= terr_d;
      cerr_q      <= cerr_d;
    end
  end

  // Result file and registered read port; the read sees the pre-write value.
  always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
    if (!reset_sink_reset_n) begin
      for (int i = 0; i < NUM_CH; i++) res_q[i] <= '0;
      vld_q <= '0;
      rd_q  <= '0;
    end else begin
      rd_q <= 32'(rd_addr) < NUM_CH ? res_q[rd_addr] : 12'd0;
      if (wr) begin
        res_q[slot_q] <= response_data;
        vld_q[slot_q] <= 1'b1;
      end
    end
  end
endmodule
